// File: rtl/semaforo_secuenciador_pkg.sv
// Shared phase codes for the traffic-light sequencer and the LED decoder.
package semaforo_secuenciador_pkg;

  localparam logic [2:0] C_VF   = 3'b000;
  localparam logic [2:0] C_VFB  = 3'b001;
  localparam logic [2:0] C_VBFB = 3'b010;
  localparam logic [2:0] C_V    = 3'b011;
  localparam logic [2:0] C_VB   = 3'b100;
  localparam logic [2:0] C_AMA  = 3'b101;
  localparam logic [2:0] C_ROJ  = 3'b110;
  localparam logic [2:0] C_TEST = 3'b111;

  // Sequencer states share their encoding with the lamp code they drive.
  typedef enum logic [2:0] {
    S_VF   = C_VF,
    S_VFB  = C_VFB,
    S_VBFB = C_VBFB,
    S_V    = C_V,
    S_VB   = C_VB,
    S_AMA  = C_AMA,
    S_ROJ  = C_ROJ
  } phase_t;

  function automatic phase_t next_phase(input phase_t s);
    case (s)
      S_ROJ:   return S_VF;
      S_VF:    return S_VFB;
      S_VFB:   return S_VBFB;
      S_VBFB:  return S_V;
      S_V:     return S_VB;
      S_VB:    return S_AMA;
      S_AMA:   return S_ROJ;
      default: return S_ROJ;
    endcase
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/semaforo_prescaler.sv
// Time-tick prescaler: one-cycle tick every DIV enabled clk cycles.
module semaforo_prescaler #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Free-running 0..DIV-1 counter, held when disabled, zeroed by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/semaforo_secuenciador.sv
// Traffic-light phase sequencer with pedestrian shortening of V and lamp test.
module semaforo_secuenciador
  import semaforo_secuenciador_pkg::*;
#(
  parameter int unsigned DIV     = 50_000_000,
  parameter int unsigned T_ROJ   = 10,
  parameter int unsigned T_VF    = 5,
  parameter int unsigned T_VFB   = 2,
  parameter int unsigned T_VBFB  = 2,
  parameter int unsigned T_V     = 8,
  parameter int unsigned T_VB    = 2,
  parameter int unsigned T_AMA   = 3,
  parameter int unsigned T_V_MIN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       test,
  input  logic       peat_req,
  output logic [2:0] semafOut,
  output logic       phase_start
);

  localparam int unsigned T_MAX = max2(max2(max2(T_ROJ, T_VF), max2(T_VFB, T_VBFB)),
                                       max2(max2(T_V, T_VB), T_AMA));
  localparam int unsigned CW = cnt_width(T_MAX);
  localparam logic [CW-1:0] VMIN_M1 = CW'(T_V_MIN - 1);

  phase_t        state, state_n, nxt;
  logic [CW-1:0] pcnt, pcnt_n, dur_m1;
  logic          latch, latch_n;
  logic [2:0]    out_n;
  logic          ps_n;
  logic          tick, in_test, clr, advance;

  // Prescaler stays cleared through the release edge so ROJ restarts from count 0.
  assign in_test = (semafOut == C_TEST);
  assign clr     = test | in_test;

  semaforo_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  // Last counter value of the current phase.
  always_comb begin
    dur_m1 = CW'(T_ROJ - 1);
    case (state)
      S_VF:    dur_m1 = CW'(T_VF - 1);
      S_VFB:   dur_m1 = CW'(T_VFB - 1);
      S_VBFB:  dur_m1 = CW'(T_VBFB - 1);
      S_V:     dur_m1 = CW'(T_V - 1);
      S_VB:    dur_m1 = CW'(T_VB - 1);
      S_AMA:   dur_m1 = CW'(T_AMA - 1);
      default: dur_m1 = CW'(T_ROJ - 1);
    endcase
  end

  // Next state, phase timer, pedestrian latch and output code.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    latch_n = latch | peat_req;
    out_n   = semafOut;
    ps_n    = 1'b0;
    nxt     = next_phase(state);
    advance = (pcnt == dur_m1) || (state == S_V && latch && pcnt >= VMIN_M1);
    if (test) begin
      state_n = S_ROJ;
      pcnt_n  = '0;
      latch_n = 1'b0;
      out_n   = C_TEST;
    end else if (in_test) begin
      state_n = S_ROJ;
      pcnt_n  = '0;
      latch_n = peat_req;
      out_n   = C_ROJ;
      ps_n    = 1'b1;
    end else if (tick) begin
      if (advance) begin
        state_n = nxt;
        pcnt_n  = '0;
        out_n   = nxt;
        ps_n    = 1'b1;
        if (nxt == S_ROJ) latch_n = peat_req;
      end else begin
        pcnt_n = pcnt + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_ROJ;
      pcnt        <= '0;
      latch       <= 1'b0;
      semafOut    <= C_ROJ;
      phase_start <= 1'b0;
    end else begin
      state       <= state_n;
      pcnt        <= pcnt_n;
      latch       <= latch_n;
      semafOut    <= out_n;
      phase_start <= ps_n;
    end
  end

endmodule
